// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if -- request/response bus between a load/store unit and
// the data memory controller.
//
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both high. The master must hold its request fields stable
// while req_valid is high. There is no response backpressure: rsp_valid is a
// one-cycle strobe that the master must take when it is high. rsp_error and
// rsp_rdata are meaningful only while rsp_valid is high.
//
// Signals:
//   req_valid  master->slave  request present
//   req_ready  slave->master  controller can accept a request this cycle
//   req_write  master->slave  1 store, 0 load
//   req_addr   master->slave  byte address [ADDR_WIDTH-1:0]
//   req_funct3 master->slave  RV32I load/store size code
//   req_wdata  master->slave  store data, right-aligned
//   rsp_valid  slave->master  response strobe
//   rsp_rdata  slave->master  extended load data (0 for stores and errors)
//   rsp_error  slave->master  request faulted
interface data_mem_ctrl_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [2:0]            req_funct3;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_funct3, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_funct3, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl -- RV32I data memory with a byte-lane store path, a fixed
// latency load pipeline and a power-up clear.
//
// After reset the controller walks every word and writes zero (INIT, one
// word per cycle, req_ready low). It then enters RUN, where it accepts one
// request per cycle and answers each with a single rsp_valid pulse exactly
// READ_LATENCY cycles later, in acceptance order.
//
// Parameters:
//   NUM_WORDS    storage depth in 32-bit words (power of two, 4..4096)
//   ADDR_WIDTH   byte-address width (>= log2(NUM_WORDS)+2)
//   READ_LATENCY accept-to-response cycles (1..4)
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-low reset
//   bus        data_mem_ctrl_if slave modport (request/response)
//   init_done  high once the memory clear has completed
//   dbg_state  current FSM state (0 INIT, 1 RUN)
//
// Optional feature: define DATA_MEM_MISALIGN_TRAP_EN to fault misaligned
// halfword/word accesses. Without it, such addresses are aligned down.
module data_mem_ctrl #(
  parameter int NUM_WORDS    = 256,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_ctrl_if.slave bus,
  output logic           init_done,
  output logic           dbg_state
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int LAST  = READ_LATENCY - 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_ptr_q, clr_ptr_d;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_INIT;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == ST_INIT) begin
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == IDX_W'(NUM_WORDS - 1)) begin
        state_d = ST_RUN;
      end
    end
  end

  assign bus.req_ready = (state_q == ST_RUN);
  assign init_done     = (state_q == ST_RUN);
  assign dbg_state     = state_q;

  // ------------------------------------------------------ request decode
  logic             accept;
  logic [1:0]       off_raw;
  logic [1:0]       eff_off;
  logic [IDX_W-1:0] req_idx;
  logic             addr_oor;
  logic             illegal_f3;
  logic             misalign;
  logic             req_err;

  assign accept  = bus.req_valid & bus.req_ready;
  assign off_raw = bus.req_addr[1:0];
  assign req_idx = bus.req_addr[IDX_W+1:2];

  // Upper word-index bits beyond the storage depth mean the access is out
  // of range; there is no wrap-around.
  generate
    if (ADDR_WIDTH > IDX_W + 2) begin : g_oor
      assign addr_oor = |bus.req_addr[ADDR_WIDTH-1:IDX_W+2];
    end else begin : g_no_oor
      assign addr_oor = 1'b0;
    end
  endgenerate

  assign illegal_f3 = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                      (bus.req_funct3 == 3'b111) ||
                      (bus.req_write && bus.req_funct3[2]);

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  assign misalign = ((bus.req_funct3[1:0] == 2'b01) && off_raw[0]) ||
                    ((bus.req_funct3[1:0] == 2'b10) && (off_raw != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_err = addr_oor | illegal_f3 | misalign;

  // Byte offset after aligning down to the access size (funct3[1:0] is the
  // size for both signed and unsigned loads).
  always_comb begin
    eff_off = 2'b00;
    case (bus.req_funct3[1:0])
      2'b00:   eff_off = off_raw;
      2'b01:   eff_off = {off_raw[1], 1'b0};
      default: eff_off = 2'b00;
    endcase
  end

  // ------------------------------------------------------ write port mux
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [3:0]       mem_mask;
  logic [31:0]      mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = req_idx;
    mem_mask  = 4'b0000;
    mem_wdata = 32'h0;
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_idx   = clr_ptr_q;
      mem_mask  = 4'b1111;
      mem_wdata = 32'h0;
    end else if (accept && bus.req_write && !req_err) begin
      mem_we = 1'b1;
      case (bus.req_funct3[1:0])
        2'b00: begin
          mem_mask  = 4'b0001 << eff_off;
          mem_wdata = {4{bus.req_wdata[7:0]}};
        end
        2'b01: begin
          mem_mask  = eff_off[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{bus.req_wdata[15:0]}};
        end
        default: begin
          mem_mask  = 4'b1111;
          mem_wdata = bus.req_wdata;
        end
      endcase
    end
  end

  // ---------------------------------------------------- storage + data pipe
  // The read of stage 0 samples the array before this edge's write lands,
  // so a load always sees stores accepted on earlier edges.
  logic [31:0] mem       [NUM_WORDS];
  logic [31:0] word_pipe [READ_LATENCY];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && mem_mask[b]) begin
        mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    word_pipe[0] <= mem[req_idx];
    for (int i = 1; i < READ_LATENCY; i++) begin
      word_pipe[i] <= word_pipe[i-1];
    end
  end

  // ------------------------------------------------- control pipe (reset)
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [READ_LATENCY-1:0] pipe_err;
  logic [READ_LATENCY-1:0] pipe_load;
  logic [2:0]              pipe_f3  [READ_LATENCY];
  logic [1:0]              pipe_off [READ_LATENCY];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      pipe_load  <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_f3[i]  <= 3'b000;
        pipe_off[i] <= 2'b00;
      end
    end else begin
      pipe_valid[0] <= accept;
      pipe_err[0]   <= req_err;
      pipe_load[0]  <= ~bus.req_write;
      pipe_f3[0]    <= bus.req_funct3;
      pipe_off[0]   <= eff_off;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_load[i]  <= pipe_load[i-1];
        pipe_f3[i]    <= pipe_f3[i-1];
        pipe_off[i]   <= pipe_off[i-1];
      end
    end
  end

  function automatic logic [31:0] load_extend(input logic [31:0] w,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [31:0] sh;
    logic [31:0] res;
    sh = w >> {off, 3'b000};
    case (f3)
      3'b000:  res = {{24{sh[7]}}, sh[7:0]};
      3'b001:  res = {{16{sh[15]}}, sh[15:0]};
      3'b100:  res = {24'h0, sh[7:0]};
      3'b101:  res = {16'h0, sh[15:0]};
      default: res = w;
    endcase
    return res;
  endfunction

  assign bus.rsp_valid = pipe_valid[LAST];
  assign bus.rsp_error = pipe_valid[LAST] & pipe_err[LAST];
  assign bus.rsp_rdata = (pipe_valid[LAST] && !pipe_err[LAST] && pipe_load[LAST]) ?
                         load_extend(word_pipe[LAST], pipe_f3[LAST], pipe_off[LAST]) :
                         32'h0;

endmodule
